// File: rtl/filter_seq_pkg.sv
// filter_seq_pkg: shared state encoding, counter widths and default timing constants
// for the filter chain sequencer.
package filter_seq_pkg;

   localparam int CNT_W       = 8;     // delay counter width
   localparam int WAIT_W      = 16;    // watchdog counter width
   localparam int DEF_DELAY   = 5;
   localparam int DEF_TIMEOUT = 1000;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SET_SENSOR,
      ST_SET_START,
      ST_WAIT_Q1,
      ST_SET_Q1,
      ST_WAIT_Q2,
      ST_SET_Q2,
      ST_WAIT_ACT,
      ST_CLR_START,
      ST_CLR_SENSOR,
      ST_CLR_Q1,
      ST_CLR_Q2,
      ST_WAIT_CLR
   } state_t;

endpackage

// File: rtl/seq_delay_timer.sv
// seq_delay_timer: 8-bit saturating step timer. Cleared by load, counts while enabled,
// flags terminal count once DELAY cycles have been spent in the current step.
module seq_delay_timer
   import filter_seq_pkg::*;
#(
   parameter int DELAY = DEF_DELAY
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic enable,
   output logic tc
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DELAY);

   logic [CNT_W-1:0] cnt;

   // count cycles since the last load; stick at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (rst || load) begin
         cnt <= '0;
      end else if (enable && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt >= LIMIT);

endmodule

// File: rtl/filter_chain_sequencer.sv
// filter_chain_sequencer: walks a three-cell chain through set / wait / clear steps,
// with timed steps spaced by DELAY and waits on synchronized cell outputs.
// Optional watchdog on the wait states: define FILTER_SEQ_TIMEOUT_EN.
module filter_chain_sequencer
   import filter_seq_pkg::*;
#(
   parameter int DELAY   = DEF_DELAY,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic go,
   input  logic qs1_out,
   input  logic qs2_out,
   input  logic actuator,
   output logic sensor,
   output logic start,
   output logic qs1_in,
   output logic qs2_in,
   output logic busy,
   output logic done,
   output logic error
);

   state_t     state, state_nx;
   logic [2:0] cells_p0, cells_p1;
   logic       q1_s, q2_s, act_s;
   logic       sensor_nx, start_nx, qs1_in_nx, qs2_in_nx;
   logic       done_nx, error_nx;
   logic       timed, tc, tmo;

   // two-flop synchronizers for the asynchronous cell outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         cells_p0 <= '0;
         cells_p1 <= '0;
      end else begin
         cells_p0 <= {actuator, qs2_out, qs1_out};
         cells_p1 <= cells_p0;
      end
   end

   assign q1_s  = cells_p1[0];
   assign q2_s  = cells_p1[1];
   assign act_s = cells_p1[2];

   seq_delay_timer #(.DELAY(DELAY)) u_timer (
      .clk    (clk),
      .rst    (reset),
      .load   (state_nx != state),
      .enable (timed),
      .tc     (tc)
   );

`ifdef FILTER_SEQ_TIMEOUT_EN
   localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(TIMEOUT - 1);

   logic [WAIT_W-1:0] wcnt;
   logic              wait_st;

   assign wait_st = (state == ST_WAIT_Q1) || (state == ST_WAIT_Q2) ||
                    (state == ST_WAIT_ACT) || (state == ST_WAIT_CLR);

   // cycles spent in the current wait state, restarted on every state change
   always_ff @(posedge clk) begin
      if (reset || (state_nx != state)) begin
         wcnt <= '0;
      end else if (wait_st && (wcnt != '1)) begin
         wcnt <= wcnt + 1'b1;
      end
   end

   assign tmo = wait_st && (wcnt >= TMO_LAST);
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign tmo = 1'b0;
`endif

   // next state and next drive values; drives only change on the step that owns them
   always_comb begin
      state_nx  = state;
      sensor_nx = sensor;
      start_nx  = start;
      qs1_in_nx = qs1_in;
      qs2_in_nx = qs2_in;
      done_nx   = 1'b0;
      error_nx  = error;
      timed     = 1'b0;
      case (state)
         ST_IDLE: if (go) begin
            state_nx = ST_SET_SENSOR;
            error_nx = 1'b0;
         end
         ST_SET_SENSOR: begin
            timed = 1'b1;
            if (tc) begin sensor_nx = 1'b1; state_nx = ST_SET_START; end
         end
         ST_SET_START: begin
            timed = 1'b1;
            if (tc) begin start_nx = 1'b1; state_nx = ST_WAIT_Q1; end
         end
         ST_WAIT_Q1: if (q1_s) state_nx = ST_SET_Q1;
         ST_SET_Q1: begin
            timed = 1'b1;
            if (tc) begin qs1_in_nx = 1'b1; state_nx = ST_WAIT_Q2; end
         end
         ST_WAIT_Q2: if (q2_s) state_nx = ST_SET_Q2;
         ST_SET_Q2: begin
            timed = 1'b1;
            if (tc) begin qs2_in_nx = 1'b1; state_nx = ST_WAIT_ACT; end
         end
         ST_WAIT_ACT: if (act_s) state_nx = ST_CLR_START;
         ST_CLR_START: begin
            timed = 1'b1;
            if (tc) begin start_nx = 1'b0; state_nx = ST_CLR_SENSOR; end
         end
         ST_CLR_SENSOR: begin
            timed = 1'b1;
            if (tc) begin sensor_nx = 1'b0; state_nx = ST_CLR_Q1; end
         end
         ST_CLR_Q1: begin
            timed = 1'b1;
            if (tc) begin qs1_in_nx = 1'b0; state_nx = ST_CLR_Q2; end
         end
         ST_CLR_Q2: begin
            timed = 1'b1;
            if (tc) begin qs2_in_nx = 1'b0; state_nx = ST_WAIT_CLR; end
         end
         ST_WAIT_CLR: if (!q1_s && !q2_s && !act_s) begin
            state_nx = ST_IDLE;
            done_nx  = 1'b1;
         end
         default: state_nx = ST_IDLE;
      endcase
      // watchdog only fires when the awaited condition did not arrive this cycle
      if (tmo && (state_nx == state)) begin
         state_nx  = ST_IDLE;
         sensor_nx = 1'b0;
         start_nx  = 1'b0;
         qs1_in_nx = 1'b0;
         qs2_in_nx = 1'b0;
         error_nx  = 1'b1;
      end
   end

   // state, registered cell drives and status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         sensor <= 1'b0;
         start  <= 1'b0;
         qs1_in <= 1'b0;
         qs2_in <= 1'b0;
         done   <= 1'b0;
         error  <= 1'b0;
      end else begin
         state  <= state_nx;
         sensor <= sensor_nx;
         start  <= start_nx;
         qs1_in <= qs1_in_nx;
         qs2_in <= qs2_in_nx;
         done   <= done_nx;
         error  <= error_nx;
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_filter_chain_sequencer.sv
// tb_filter_chain_sequencer: directed vector table plus randomized run against a
// step-list reference model of the chain sequence.
module tb_filter_chain_sequencer;

   localparam int DLY = 5;
   localparam int TMO = 50;
`ifdef FILTER_SEQ_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1, go = 1'b0;
   logic qs1_out = 1'b0, qs2_out = 1'b0, actuator = 1'b0;
   logic sensor, start, qs1_in, qs2_in, busy, done, error;

   int errors = 0;
   int checks = 0;

   filter_chain_sequencer #(.DELAY(DLY), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .go(go),
      .qs1_out(qs1_out), .qs2_out(qs2_out), .actuator(actuator),
      .sensor(sensor), .start(start), .qs1_in(qs1_in), .qs2_in(qs2_in),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // environment: each cell answers its drive 'lat' cycles later, with knobs
   // to block, force high or glitch low each cell output
   logic ds [32];
   logic d1 [32];
   logic d2 [32];
   int   lat = 10;
   logic [2:0] blk = '0, frc = '0, glt = '0;

   // reference model: sequence as a list of steps {timed?, drive index / wait target, value}
   typedef struct { bit timed; int sig; bit val; } step_t;
   step_t steps [13];
   int   m_step = 0, m_age = 0;
   logic [3:0] m_drv = '0;   // [0]=sensor [1]=start [2]=qs1_in [3]=qs2_in
   logic m_done = 1'b0, m_err = 1'b0;
   logic [2:0] s1 = '0, s2 = '0;   // cell values captured one and two edges ago

   typedef struct { int at; logic [6:0] exp; } vec_t;
   vec_t vt [20];

   function automatic logic [6:0] outs();
      return {sensor, start, qs1_in, qs2_in, busy, done, error};
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
      end
   endtask

   task automatic model_edge(input logic g, input logic r, input logic [2:0] ci);
      logic cond;
      m_done = 1'b0;
      if (r) begin
         m_step = 0; m_age = 0; m_drv = '0; m_err = 1'b0; s1 = '0; s2 = '0;
         return;
      end
      if (m_step == 0) begin
         if (g) begin m_step = 1; m_age = 0; m_err = 1'b0; end
      end else if (steps[m_step].timed) begin
         if (m_age >= DLY) begin
            m_drv[steps[m_step].sig] = steps[m_step].val;
            m_step++; m_age = 0;
         end else m_age++;
      end else begin
         cond = (steps[m_step].sig == 3) ? (s2 == 3'b000) : s2[steps[m_step].sig];
         if (cond) begin
            if (m_step == 12) begin m_step = 0; m_done = 1'b1; end
            else m_step++;
            m_age = 0;
         end else if (TMO_EN && (m_age >= TMO - 1)) begin
            m_step = 0; m_age = 0; m_drv = '0; m_err = 1'b1;
         end else m_age++;
      end
      s2 = s1;
      s1 = ci;
   endtask

   task automatic env_update();
      for (int k = 31; k > 0; k--) begin
         ds[k] = ds[k-1]; d1[k] = d1[k-1]; d2[k] = d2[k-1];
      end
      ds[0] = start; d1[0] = qs1_in; d2[0] = qs2_in;
      qs1_out  = ((ds[lat] & ~blk[0]) | frc[0]) & ~glt[0];
      qs2_out  = ((d1[lat] & ~blk[1]) | frc[1]) & ~glt[1];
      actuator = ((d2[lat] & ~blk[2]) | frc[2]) & ~glt[2];
   endtask

   // one clock: capture pre-edge inputs, advance model, compare, update environment
   task automatic tick();
      logic g, r;
      logic [2:0] ci;
      g = go; r = reset; ci = {actuator, qs2_out, qs1_out};
      @(posedge clk);
      #1;
      model_edge(g, r, ci);
      chk("cycle", outs(),
          {m_drv[0], m_drv[1], m_drv[2], m_drv[3], m_step != 0, m_done, m_err});
      env_update();
   endtask

   task automatic settle();
      blk = '0; frc = '0; glt = '0; go = 1'b0; lat = 10;
      for (int k = 0; k < 40; k++) tick();
   endtask

   initial begin
      int n, rel, dn;
      for (int k = 0; k < 32; k++) begin ds[k] = 1'b0; d1[k] = 1'b0; d2[k] = 1'b0; end
      steps[0]  = '{1'b0, 0, 1'b0};
      steps[1]  = '{1'b1, 0, 1'b1};  steps[2]  = '{1'b1, 1, 1'b1};
      steps[3]  = '{1'b0, 0, 1'b1};  steps[4]  = '{1'b1, 2, 1'b1};
      steps[5]  = '{1'b0, 1, 1'b1};  steps[6]  = '{1'b1, 3, 1'b1};
      steps[7]  = '{1'b0, 2, 1'b1};  steps[8]  = '{1'b1, 1, 1'b0};
      steps[9]  = '{1'b1, 0, 1'b0};  steps[10] = '{1'b1, 2, 1'b0};
      steps[11] = '{1'b1, 3, 1'b0};  steps[12] = '{1'b0, 3, 1'b0};
      // {edge after go, {sensor,start,qs1_in,qs2_in,busy,done,error}} for DELAY=5, cells 10 late
      vt[0]  = '{0,   7'b0000100}; vt[1]  = '{5,   7'b0000100};
      vt[2]  = '{6,   7'b1000100}; vt[3]  = '{11,  7'b1000100};
      vt[4]  = '{12,  7'b1100100}; vt[5]  = '{30,  7'b1100100};
      vt[6]  = '{31,  7'b1110100}; vt[7]  = '{49,  7'b1110100};
      vt[8]  = '{50,  7'b1111100}; vt[9]  = '{68,  7'b1111100};
      vt[10] = '{69,  7'b1011100}; vt[11] = '{74,  7'b1011100};
      vt[12] = '{75,  7'b0011100}; vt[13] = '{80,  7'b0011100};
      vt[14] = '{81,  7'b0001100}; vt[15] = '{86,  7'b0001100};
      vt[16] = '{87,  7'b0000100}; vt[17] = '{99,  7'b0000100};
      vt[18] = '{100, 7'b0000010}; vt[19] = '{101, 7'b0000000};

      // reset with go held high: go must be ignored
      reset = 1'b1; go = 1'b1;
      tick(); tick();
      chk("reset_state", outs(), 7'b0000000);
      reset = 1'b0; go = 1'b0;
      settle();

      // full nominal run, checked against the hand-derived timeline
      go = 1'b1; tick(); go = 1'b0; rel = 0;
      for (int i = 0; i < 20; i++) begin
         while (rel < vt[i].at) begin tick(); rel++; end
         chk("nominal", outs(), vt[i].exp);
      end
      settle();

      // qs2_out already high: WAIT_Q2 passes on its first cycle
      frc[1] = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      go = 1'b1; tick(); go = 1'b0;
      n = 0;
      while (!qs1_in && n < 300) begin tick(); n++; end
      chk("early_q1in", qs1_in, 1'b1);
      for (int k = 0; k < 6; k++) tick();
      chk("early_q2_before", qs2_in, 1'b0);
      tick();
      chk("early_q2_at", {qs2_in, error}, 2'b10);
      frc[1] = 1'b0;
      n = 0;
      while (!done && n < 400) begin tick(); n++; end
      chk("early_done", done, 1'b1);
      settle();

      // reset in WAIT_ACT: drives drop at once, no done
      blk[2] = 1'b1;
      go = 1'b1; tick(); go = 1'b0;
      n = 0;
      while (!qs2_in && n < 300) begin tick(); n++; end
      chk("rst_q2in", qs2_in, 1'b1);
      for (int k = 0; k < 3; k++) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rst_mid", outs(), 7'b0000000);
      dn = 0;
      for (int k = 0; k < 20; k++) begin tick(); dn += int'(done); end
      chk("rst_no_done", 8'(dn), 8'd0);
      settle();

`ifdef FILTER_SEQ_TIMEOUT_EN
      // actuator stuck low: watchdog fires TMO cycles after WAIT_ACT entry
      blk[2] = 1'b1;
      go = 1'b1; tick(); go = 1'b0;
      n = 0;
      while (!qs2_in && n < 300) begin tick(); n++; end
      chk("tmo_q2in", qs2_in, 1'b1);
      for (int k = 0; k < TMO - 1; k++) tick();
      chk("tmo_before", outs(), 7'b1111100);
      tick();
      chk("tmo_at", outs(), 7'b0000001);
      for (int k = 0; k < 4; k++) tick();
      chk("tmo_sticky", error, 1'b1);
      go = 1'b1; tick(); go = 1'b0;
      chk("tmo_cleared", {busy, error}, 2'b10);
      blk[2] = 1'b0;
      n = 0;
      while (!done && n < 400) begin tick(); n++; end
      chk("tmo_rerun_done", done, 1'b1);
      settle();
`endif

      // randomized run: go spam while busy, glitches, early forcing, rare resets
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 0) lat = $urandom_range(3, 20);
         go = ($urandom_range(0, 7) == 0);
         reset = ($urandom_range(0, 299) == 0);
         for (int b = 0; b < 3; b++) begin
            glt[b] = ($urandom_range(0, 15) == 0);
            frc[b] = ($urandom_range(0, 39) == 0);
         end
         tick();
      end
      reset = 1'b0;
      settle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/filter_chain_sequencer.md
FILTER_CHAIN_SEQUENCER -- requirements
Module: filter_chain_sequencer

Interface
REQ-001 SHALL have parameter DELAY, default 5, cycles between successive timed output changes (legal 1..255).
REQ-002 SHALL have parameter TIMEOUT, default 1000, max cycles spent in any wait state (used only with REQ-027).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port go  input  1  one-cycle request to run one full chain cycle.
REQ-006 SHALL have ports qs1_out, qs2_out, actuator  input  1 each  asynchronous outputs of cells 1, 2, 3.
REQ-007 SHALL have ports sensor, start, qs1_in, qs2_in  output  1 each  registered drives to cell Sensor/Start inputs.
REQ-008 SHALL have ports busy, done, error  output  1 each  status: run active, one-cycle completion pulse, timeout flag.

Function
REQ-009 SHALL pass qs1_out, qs2_out, actuator through two-flop synchronizers; all state decisions use synchronized values (2-cycle input latency).
REQ-010 SHALL implement states IDLE, SET_SENSOR, SET_START, WAIT_Q1, SET_Q1, WAIT_Q2, SET_Q2, WAIT_ACT, CLR_START, CLR_SENSOR, CLR_Q1, CLR_Q2, WAIT_CLR.
REQ-011 IDLE: go=1 -> SET_SENSOR; go ignored in all other states (no queueing).
REQ-012 Each SET_*/CLR_* state SHALL hold DELAY cycles, then on the next edge update its output and advance; the output change occurs exactly DELAY+1 edges after state entry.
REQ-013 Order: sensor=1, start=1, wait sync qs1_out=1, qs1_in=1, wait sync qs2_out=1, qs2_in=1, wait sync actuator=1, start=0, sensor=0, qs1_in=0, qs2_in=0, wait all three synced inputs 0.
REQ-014 WAIT_* states SHALL advance on the first cycle the awaited condition is true; the timed state's counter starts at entry.
REQ-015 WAIT_CLR exit SHALL pulse done for exactly one cycle and return to IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 Outputs sensor/start/qs1_in/qs2_in SHALL be driven from flops only, never combinationally from inputs.
REQ-018 A cell output that rises early (e.g. qs2_out before WAIT_Q2) SHALL be accepted when its wait state is reached; no error.
REQ-019 A cell output that falls during its later wait (glitch) SHALL NOT roll back the sequence.
REQ-020 Delay counter SHALL be 8 bits, reload to 0 on every state change, saturate, never wrap.

Reset
REQ-021 reset=1 at any edge SHALL force IDLE, counter 0, synchronizers 0, all outputs 0, error 0, regardless of state.
REQ-022 Reset mid-run SHALL drop all cell drives to 0 at the same edge; no done pulse.
REQ-023 go asserted in the reset cycle SHALL be ignored.

Configuration
REQ-024 Macro FILTER_SEQ_TIMEOUT_EN SHALL compile in a watchdog.
REQ-025 Without it: wait states wait indefinitely; error tied 0; TIMEOUT unused.
REQ-026 With it: a wait-state cycle counter (16 bits) counts cycles in the current WAIT_* state.
REQ-027 With it: reaching TIMEOUT SHALL set error (sticky until reset or next go), clear all four drives at once, go to IDLE without done.

Structure
REQ-028 Package filter_seq_pkg SHALL hold the state enumeration, the 8-bit counter width constant and default DELAY/TIMEOUT constants.
REQ-029 Sub-module seq_delay_timer (load, enable, terminal-count flag) SHALL implement the delay counter; synchronizers stay inline.

Verification
REQ-030 DELAY=5, go at cycle 0, cells respond 10 cycles after each drive -> sensor at 6, start at 12, done once, all outputs 0 after, busy low after done.
REQ-031 qs2_out forced 1 before run -> WAIT_Q2 passes in 1 cycle after SET_Q2 entry condition; no error.
REQ-032 reset asserted while in WAIT_ACT (qs2_in=1) -> next edge all drives 0, state IDLE, done never pulses.
REQ-033 With FILTER_SEQ_TIMEOUT_EN, TIMEOUT=50, actuator stuck 0 -> error=1 exactly 50 cycles after WAIT_ACT entry, drives 0; next go clears error.
REQ-034 go pulsed repeatedly while busy -> exactly one done per accepted go, sequence unchanged.
REQ-035 DELAY=1 -> each timed step spaced 2 edges; sequence order per REQ-013 preserved.
